// File: rtl/counter_pkg.sv
// Shared types and defaults for the event counter and its synchronizer.
`timescale 1ns/1ps
package counter_pkg;

  typedef enum logic {
    CNT_LEVEL = 1'b0,
    CNT_EDGE  = 1'b1
  } cnt_mode_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MIN_SYNC_STAGES = 2;

  function automatic cnt_mode_e mode_from_param(input int edge_mode);
    return (edge_mode != 0) ? CNT_EDGE : CNT_LEVEL;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer; every stage clears to 0 on the asynchronous reset.
`timescale 1ns/1ps
module sync_chain
  import counter_pkg::*;
#(
  parameter int N = MIN_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (N < MIN_SYNC_STAGES) begin : g_bad_depth
    $error("sync_chain: N must be at least 2");
  end

  logic [N-1:0] stages_q;
  logic [N-1:0] stages_d;

  always_comb begin
    stages_d = {stages_q[N-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages_q <= '0;
    end else begin
      stages_q <= stages_d;
    end
  end

  assign q = stages_q[N-1];

endmodule

// File: rtl/event_counter.sv
// Activity counter: optional input synchronizer, level/edge qualification,
// wrapping or saturating increment into a registered count.
`timescale 1ns/1ps
module event_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SATURATE    = 0,
  parameter int EDGE_MODE   = 0,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic [WIDTH-1:0] counter
);

  localparam cnt_mode_e MODE = mode_from_param(EDGE_MODE);

  if (WIDTH < 2) begin : g_bad_width
    $error("event_counter: WIDTH must be at least 2");
  end

  if (SYNC_STAGES == 1 || SYNC_STAGES < 0) begin : g_bad_sync
    $error("event_counter: SYNC_STAGES must be 0 or >= 2");
  end

  logic             q_in;
  logic             prev_q;
  logic             prev_d;
  logic             event_hit;
  logic             at_max;
  logic [WIDTH-1:0] counter_q;
  logic [WIDTH-1:0] counter_d;

  if (SYNC_STAGES >= MIN_SYNC_STAGES) begin : g_sync
    sync_chain #(
      .N(SYNC_STAGES)
    ) u_sync_chain (
      .clk(clk),
      .rst(rst),
      .d  (in),
      .q  (q_in)
    );
  end else begin : g_direct
    assign q_in = in;
  end

  // Edge detect compares against last cycle's qualified input, so no extra latency.
  always_comb begin
    prev_d    = q_in;
    event_hit = (MODE == CNT_EDGE) ? (q_in & ~prev_q) : q_in;
    at_max    = &counter_q;
    counter_d = counter_q;
    if (event_hit) begin
      if (!((SATURATE != 0) && at_max)) begin
        counter_d = counter_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= 1'b0;
      counter_q <= '0;
    end else begin
      prev_q    <= prev_d;
      counter_q <= counter_d;
    end
  end

  assign counter = counter_q;

`ifndef SYNTHESIS
  in_known_a : assert property (@(posedge clk) disable iff (rst) !$isunknown(in))
    else $error("event_counter: X/Z on in while out of reset");
`endif

endmodule

// File: tb/tb_event_counter.sv
// Directed bench for event_counter across level/wrap, saturate, edge and synchronized configurations.
`timescale 1ns/1ps
module tb_event_counter;

  logic       clk;
  logic       rst;
  logic       inLvl;
  logic       inSat;
  logic       inEdge;
  logic       inSync;
  logic [7:0] cntLvl;
  logic [7:0] cntSat;
  logic [7:0] cntEdge;
  logic [7:0] cntSync;

  int checks;
  int errors;

  event_counter #(.WIDTH(8), .SATURATE(0), .EDGE_MODE(0), .SYNC_STAGES(0)) dutLvl (
    .clk(clk), .rst(rst), .in(inLvl), .counter(cntLvl)
  );

  event_counter #(.WIDTH(8), .SATURATE(1), .EDGE_MODE(0), .SYNC_STAGES(0)) dutSat (
    .clk(clk), .rst(rst), .in(inSat), .counter(cntSat)
  );

  event_counter #(.WIDTH(8), .SATURATE(0), .EDGE_MODE(1), .SYNC_STAGES(0)) dutEdge (
    .clk(clk), .rst(rst), .in(inEdge), .counter(cntEdge)
  );

  event_counter #(.WIDTH(8), .SATURATE(0), .EDGE_MODE(0), .SYNC_STAGES(2)) dutSync (
    .clk(clk), .rst(rst), .in(inSync), .counter(cntSync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Synchronous-looking reset pulse aligned to negedges, all inputs low.
  task automatic applyStimulus();
    @(negedge clk);
    rst    = 1'b1;
    inLvl  = 1'b0;
    inSat  = 1'b0;
    inEdge = 1'b0;
    inSync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    inLvl  = 1'b1;
    inSat  = 1'b1;
    inEdge = 1'b1;
    inSync = 1'b1;

    // Reset held with clock running and inputs active
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_hold_lvl", cntLvl, 8'd0);
      checkOutput("reset_hold_sync", cntSync, 8'd0);
    end
    inLvl  = 1'b0;
    inSat  = 1'b0;
    inEdge = 1'b0;
    inSync = 1'b0;
    rst    = 1'b0;

    // Level counting
    waitCycles(10);
    checkOutput("level_idle", cntLvl, 8'd0);
    inLvl = 1'b1;
    waitCycles(1);
    checkOutput("level_first", cntLvl, 8'd1);
    waitCycles(19);
    checkOutput("level_20", cntLvl, 8'd20);
    inLvl = 1'b0;
    waitCycles(5);
    checkOutput("level_hold", cntLvl, 8'd20);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_lvl", cntLvl, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Wrap
    applyStimulus();
    inLvl = 1'b1;
    waitCycles(255);
    checkOutput("wrap_255", cntLvl, 8'd255);
    waitCycles(1);
    checkOutput("wrap_0", cntLvl, 8'd0);
    waitCycles(1);
    checkOutput("wrap_1", cntLvl, 8'd1);
    inLvl = 1'b0;

    // Saturate
    applyStimulus();
    inSat = 1'b1;
    waitCycles(254);
    checkOutput("sat_254", cntSat, 8'd254);
    waitCycles(46);
    checkOutput("sat_300", cntSat, 8'd255);
    waitCycles(10);
    checkOutput("sat_stay", cntSat, 8'd255);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("sat_rst", cntSat, 8'd0);
    @(negedge clk);
    rst   = 1'b0;
    inSat = 1'b0;

    // Edge mode: three pulses of 10, 20, 30 cycles
    applyStimulus();
    inEdge = 1'b1;
    waitCycles(1);
    checkOutput("edge_first_rise", cntEdge, 8'd1);
    waitCycles(9);
    checkOutput("edge_level_held", cntEdge, 8'd1);
    inEdge = 1'b0;
    waitCycles(5);
    inEdge = 1'b1;
    waitCycles(20);
    checkOutput("edge_second", cntEdge, 8'd2);
    inEdge = 1'b0;
    waitCycles(5);
    inEdge = 1'b1;
    waitCycles(30);
    inEdge = 1'b0;
    waitCycles(5);
    checkOutput("edge_three", cntEdge, 8'd3);

    // Synchronized input: two extra cycles of latency
    applyStimulus();
    inSync = 1'b1;
    waitCycles(2);
    checkOutput("sync_lat_2", cntSync, 8'd0);
    waitCycles(1);
    checkOutput("sync_lat_3", cntSync, 8'd1);
    waitCycles(14);
    checkOutput("sync_15", cntSync, 8'd15);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("sync_rst", cntSync, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    waitCycles(2);
    checkOutput("sync_resume_2", cntSync, 8'd0);
    waitCycles(1);
    checkOutput("sync_resume_3", cntSync, 8'd1);
    waitCycles(4);
    checkOutput("sync_resume_7", cntSync, 8'd5);
    inSync = 1'b0;

    // Untouched instances must be unaffected by other scenarios
    checkOutput("lvl_idle_end", cntLvl, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
